// File: rtl/fpc_pipe.sv
// Pipelined floating-point add/sub/mul. Accepts one operation per cycle and returns
// results in order four register banks later. Output backpressure freezes the whole pipe.
module fpc_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out,
  output logic [1:0]           out_flags
);
  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned AW = MAN_W + 4;          // hidden + mantissa + G/R/S
  localparam int unsigned NW = MAN_W + 5;          // AW plus carry-out bit
  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned PW = 2 * MAN_W + 2;
  localparam int unsigned LW = $clog2(NW);
  localparam int unsigned XW = EW + LW + 1;
  localparam logic [EXP_W-1:0]     EMAX  = '1;
  localparam logic [EW-1:0]        BIAS  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [PW-1:0]        PMASK = ~({PW{1'b1}} << (MAN_W - 2));
  localparam logic signed [XW-1:0] EINF  = XW'((1 << EXP_W) - 1);

  logic stall;

  // Operand register: raw operands with b's sign already flipped for sub.
  logic         v1_q, mul1_q;
  logic [W-1:0] a1_q, b1_q;

  // Aligned register: x is the larger-magnitude operand for add.
  logic              v2_q, mul2_q, sx2_q, sy2_q, zx2_q, zy2_q, ix2_q, iy2_q;
  logic [EXP_W-1:0]  ex2_q, ey2_q;
  logic [AW-1:0]     gx2_q, gy2_q;
  logic              sx2_d, sy2_d, zx2_d, zy2_d, ix2_d, iy2_d;
  logic [EXP_W-1:0]  ex2_d, ey2_d;
  logic [AW-1:0]     gx2_d, gy2_d;

  // Compute register: unnormalised significand with carry bit and G/R/S.
  logic          v3_q, s3_q, sp3_q;
  logic [NW-1:0] n3_q;
  logic [EW-1:0] e3_q;
  logic [W-1:0]  spv3_q;
  logic          s3_d, sp3_d;
  logic [NW-1:0] n3_d;
  logic [EW-1:0] e3_d;
  logic [W-1:0]  spv3_d;

  logic         vo_q;
  logic [W-1:0] out_q, out_d;
  logic [1:0]   flags_q, flags_d;

  assign stall     = vo_q && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = vo_q;
  assign out       = out_q;
  assign out_flags = flags_q;

  // Decode and align.
  logic [EXP_W-1:0] ea, eb, dexp;
  logic [AW-1:0]    siga, sigb, sig_s, amask;
  logic             za, zb, ia, ib, swap;
  always_comb begin
    ea    = a1_q[W-2:MAN_W];
    eb    = b1_q[W-2:MAN_W];
    za    = (ea == '0);
    zb    = (eb == '0);
    ia    = (ea == EMAX);
    ib    = (eb == EMAX);
    siga  = za ? '0 : {1'b1, a1_q[MAN_W-1:0], 3'b000};
    sigb  = zb ? '0 : {1'b1, b1_q[MAN_W-1:0], 3'b000};
    swap  = !mul1_q && ({eb, sigb} > {ea, siga});
    sx2_d = swap ? b1_q[W-1] : a1_q[W-1];
    sy2_d = swap ? a1_q[W-1] : b1_q[W-1];
    ex2_d = swap ? eb : ea;
    ey2_d = swap ? ea : eb;
    zx2_d = swap ? zb : za;
    zy2_d = swap ? za : zb;
    ix2_d = swap ? ib : ia;
    iy2_d = swap ? ia : ib;
    gx2_d = swap ? sigb : siga;
    sig_s = swap ? siga : sigb;
    dexp  = ex2_d - ey2_d;
    amask = ~({AW{1'b1}} << dexp);
    if (mul1_q)
      gy2_d = sig_s;
    else if (32'(dexp) >= MAN_W + 3)
      gy2_d = AW'(|sig_s);
    else
      gy2_d = (sig_s >> dexp) | AW'(|(sig_s & amask));
  end

  // Compute; specials are resolved here and carried alongside the datapath.
  logic [PW-1:0] prod;
  always_comb begin
    prod = PW'(gx2_q[AW-1:3]) * PW'(gy2_q[AW-1:3]);
    if (mul2_q) begin
      n3_d   = {(NW-1)'(prod >> (MAN_W - 2)), |(prod & PMASK)};
      e3_d   = {2'b00, ex2_q} + {2'b00, ey2_q} - BIAS;
      s3_d   = sx2_q ^ sy2_q;
      sp3_d  = ix2_q | iy2_q | zx2_q | zy2_q;
      spv3_d = (ix2_q | iy2_q) ? {s3_d, EMAX, {MAN_W{1'b0}}} : {s3_d, {(W-1){1'b0}}};
    end else begin
      n3_d   = (sx2_q == sy2_q) ? {1'b0, gx2_q} + {1'b0, gy2_q}
                                : {1'b0, gx2_q} - {1'b0, gy2_q};
      e3_d   = {2'b00, ex2_q};
      s3_d   = sx2_q;
      sp3_d  = ix2_q;
      spv3_d = {sx2_q & !(iy2_q && (sy2_q != sx2_q)), EMAX, {MAN_W{1'b0}}};
    end
  end

  // Normalise, round, range-check.
  logic signed [XW-1:0] ee;
  logic [LW-1:0]        lz;
  logic [NW-2:0]        nn;
  logic [MAN_W:0]       mr;
  logic                 rnd;
  always_comb begin
    ee = {{(XW-EW){e3_q[EW-1]}}, e3_q};
    lz = '0;
    if (n3_q[NW-1]) begin
      nn = {n3_q[NW-1:2], n3_q[1] | n3_q[0]};
      ee = ee + XW'(1);
    end else begin
      for (int unsigned i = 0; i < NW - 1; i++)
        if (n3_q[i]) lz = LW'(NW - 2 - i);
      nn = (NW-1)'(n3_q << lz);
      ee = ee - XW'(lz);
    end
    rnd = nn[2] & (nn[1] | nn[0] | nn[3]);
    mr  = {1'b0, nn[NW-3:3]} + (MAN_W+1)'(rnd);
    if (mr[MAN_W]) ee = ee + XW'(1);
    flags_d = 2'b00;
    if (sp3_q)
      out_d = spv3_q;
    else if (!nn[NW-2])
      out_d = '0;
    else if (ee >= EINF) begin
      out_d   = {s3_q, EMAX, {MAN_W{1'b0}}};
      flags_d = 2'b10;
    end else if (ee[XW-1] || ee == '0) begin
      out_d   = {s3_q, {(W-1){1'b0}}};
      flags_d = 2'b01;
    end else
      out_d = {s3_q, ee[EXP_W-1:0], mr[MAN_W-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0; mul1_q <= 1'b0; a1_q <= '0; b1_q <= '0;
      v2_q <= 1'b0; mul2_q <= 1'b0; sx2_q <= 1'b0; sy2_q <= 1'b0;
      zx2_q <= 1'b0; zy2_q <= 1'b0; ix2_q <= 1'b0; iy2_q <= 1'b0;
      ex2_q <= '0; ey2_q <= '0; gx2_q <= '0; gy2_q <= '0;
      v3_q <= 1'b0; s3_q <= 1'b0; sp3_q <= 1'b0; n3_q <= '0; e3_q <= '0; spv3_q <= '0;
      vo_q <= 1'b0; out_q <= '0; flags_q <= '0;
    end else if (!stall) begin
      v1_q   <= in_valid;
      mul1_q <= (mode == 2'b10);
      a1_q   <= in_a;
      b1_q   <= {in_b[W-1] ^ (mode == 2'b01), in_b[W-2:0]};
      v2_q   <= v1_q;
      mul2_q <= mul1_q;
      sx2_q  <= sx2_d; sy2_q <= sy2_d; zx2_q <= zx2_d; zy2_q <= zy2_d;
      ix2_q  <= ix2_d; iy2_q <= iy2_d; ex2_q <= ex2_d; ey2_q <= ey2_d;
      gx2_q  <= gx2_d; gy2_q <= gy2_d;
      v3_q   <= v2_q;
      s3_q   <= s3_d; sp3_q <= sp3_d; n3_q <= n3_d; e3_q <= e3_d; spv3_q <= spv3_d;
      vo_q   <= v3_q;
      out_q  <= out_d;
      flags_q <= flags_d;
    end
  end
endmodule

// File: tb/tb_fpc_pipe.sv
// Directed bench for fpc_pipe: bfloat16-style and binary16 instances, latency,
// specials, backpressure ordering and mid-stream reset.
module tb_fpc_pipe;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, h_in_ready, h_out_valid;
  logic [15:0] in_a = '0, in_b = '0, out, h_out;
  logic [1:0]  mode = '0, out_flags, h_out_flags;
  int          nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  fpc_pipe #(.EXP_W(8), .MAN_W(7)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .out_flags(out_flags));

  fpc_pipe #(.EXP_W(5), .MAN_W(10)) u_h (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(h_in_ready),
    .in_a(in_a), .in_b(in_b), .mode(mode), .out_valid(h_out_valid),
    .out_ready(out_ready), .out(h_out), .out_flags(h_out_flags));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One isolated operation: accept, confirm nothing appears early, then check result.
  task automatic op1(input string tag, input bit h, input logic [15:0] a, input logic [15:0] b,
                     input logic [1:0] m, input logic [15:0] eo, input logic [1:0] ef);
    @(negedge clk);
    out_ready = 1'b1; in_a = a; in_b = b; mode = m; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk({tag, "_early"}, 32'(h ? h_out_valid : out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_vld"}, 32'(h ? h_out_valid : out_valid), 32'd1);
    chk(tag, 32'(h ? h_out : out), 32'(eo));
    chk({tag, "_flg"}, 32'(h ? h_out_flags : out_flags), 32'(ef));
  endtask

  logic [15:0] va[6] = '{16'h3F80, 16'h4040, 16'hBFC0, 16'h3F80, 16'h3F80, 16'h4000};
  logic [15:0] vb[6] = '{16'h4000, 16'h4040, 16'h4000, 16'h3BC0, 16'h3F80, 16'h4000};
  logic [1:0]  vm[6] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10};
  logic [15:0] ve[6] = '{16'h4040, 16'h0000, 16'hC040, 16'h3F81, 16'h4000, 16'h4080};

  initial begin
    #1;
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_flg", 32'(out_flags), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_h_rdy", 32'(h_in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    op1("add",       0, 16'h3F80, 16'h4000, 2'b00, 16'h4040, 2'b00);
    op1("sub",       0, 16'h4040, 16'h4040, 2'b01, 16'h0000, 2'b00);
    op1("mul",       0, 16'h3FC0, 16'h4000, 2'b10, 16'h4040, 2'b00);
    op1("mul_neg",   0, 16'hBFC0, 16'h4000, 2'b10, 16'hC040, 2'b00);
    op1("tie",       0, 16'h3F80, 16'h3B80, 2'b00, 16'h3F80, 2'b00);
    op1("rnd_up",    0, 16'h3F80, 16'h3BC0, 2'b00, 16'h3F81, 2'b00);
    op1("ovf",       0, 16'h7F00, 16'h4000, 2'b10, 16'h7F80, 2'b10);
    op1("unf",       0, 16'h0080, 16'h0080, 2'b10, 16'h0000, 2'b01);
    op1("denorm",    0, 16'h0001, 16'h3F80, 2'b00, 16'h3F80, 2'b00);
    op1("rsvd",      0, 16'h3F80, 16'h4000, 2'b11, 16'h4040, 2'b00);
    op1("inf_sub",   0, 16'h7F80, 16'h7F80, 2'b01, 16'h7F80, 2'b00);
    op1("inf_add",   0, 16'hFF80, 16'h3F80, 2'b00, 16'hFF80, 2'b00);
    op1("zmul_inf",  0, 16'h0000, 16'h7F80, 2'b10, 16'h7F80, 2'b00);
    op1("nzero_mul", 0, 16'h8000, 16'h3F80, 2'b10, 16'h8000, 2'b00);
    op1("h_add",     1, 16'h3C00, 16'h4000, 2'b00, 16'h4200, 2'b00);
    op1("h_mul",     1, 16'h3E00, 16'h4000, 2'b10, 16'h4200, 2'b00);

    // Backpressure: a 4-deep valid model predicts out_valid and in_ready each cycle.
    begin
      logic [3:0] pv;
      logic       stall_m;
      int         sent, got;
      pv = '0; sent = 0; got = 0;
      repeat (2) @(negedge clk);
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
        @(negedge clk);
        out_ready = !(cyc >= 4 && cyc <= 8);
        in_valid  = (sent < 6);
        if (sent < 6) begin
          in_a = va[sent]; in_b = vb[sent]; mode = vm[sent];
        end
        #1;
        stall_m = pv[3] && !out_ready;
        chk("bp_ovld", 32'(out_valid), 32'(pv[3]));
        chk("bp_irdy", 32'(in_ready), 32'(!stall_m));
        if (pv[3]) chk("bp_out", 32'(out), 32'(ve[got]));
        @(posedge clk);
        if (!stall_m) begin
          if (pv[3]) got++;
          if (in_valid) sent++;
          pv = {pv[2:0], in_valid};
        end
      end
      chk("bp_count", 32'(got), 32'd6);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) @(negedge clk);
    end

    // Mid-stream reset with a stalled result on the output.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_a = 16'h3F80; in_b = 16'h4000; mode = 2'b00;
    repeat (4) @(posedge clk);
    #1 in_valid = 1'b0;
    chk("rst_pre_vld", 32'(out_valid), 32'd1);
    chk("rst_pre_out", 32'(out), 32'h4040);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_vld", 32'(out_valid), 32'd0);
    chk("mrst_out", 32'(out), 32'd0);
    chk("mrst_flg", 32'(out_flags), 32'd0);
    chk("mrst_rdy", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mrst_quiet", 32'(out_valid), 32'd0);
    end
    op1("post_rst", 0, 16'h3F80, 16'h4000, 2'b10, 16'h4000, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/fpc_pipe.md
# fpc_pipe

Parametrised, fully pipelined floating-point add/sub/mul unit, the successor of the single-shot 16-bit `Fpc` calculator. It accepts one operation per cycle under a valid/ready handshake and returns results in order after a fixed 3-stage latency. Output backpressure stalls the whole pipeline. It sits between the operand sequencer and the result collector in the datapath.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 7, stored mantissa width (≥2); word width W = 1+EXP_W+MAN_W; bias = 2^(EXP_W-1)-1
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operand pair present
- in_ready  output  1  unit can accept this cycle
- in_a, in_b  input  W  operands {sign, exponent, mantissa}
- mode  input  2  00 add (a+b), 01 sub (a−b), 10 mul, 11 reserved (executes as add)
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out  output  W  result
- out_flags  output  2  {overflow, underflow} for the result in `out`

## Operation
- Handshake: the unit accepts an operation when in_valid && in_ready. The consumer takes a result when out_valid && out_ready.
- stall = out_valid && !out_ready. in_ready = !stall (combinational). A stall freezes all three stages, including their valid bits.
- Stage 1 (decode/align):
  - Register the operands and the effective operation. Sub flips the sign of b.
  - An exponent field of 0 means zero: denormals are flushed to zero on input.
  - An exponent field of all ones means ±Inf. NaN is not supported; any all-ones exponent is treated as Inf.
  - For add, swap the operands so that |a| ≥ |b|. Right-shift the smaller significand (hidden 1 prepended) by the exponent difference, keeping guard, round and sticky bits. A shift ≥ MAN_W+3 leaves only the sticky bit.
- Stage 2 (compute):
  - Add: add or subtract the aligned significands, using the sign of the larger operand.
  - Mul: (MAN_W+1)×(MAN_W+1) significand product. Exponent = ea+eb−bias, computed at EXP_W+2 bits signed. Sign = sa^sb.
- Stage 3 (normalise/round):
  - Leading-one detect, then shift left or right by one. Adjust the exponent.
  - Round to nearest, ties to even, using guard/round/sticky. A rounding carry renormalises and increments the exponent.
- Special rules:
  - Exact-zero add/sub result is +0.
  - Zero × anything is a signed zero (sa^sb); zero × Inf gives Inf.
  - Inf ± finite gives that Inf. Inf − Inf gives +Inf.
  - Either operand Inf in mul gives a signed Inf.
  - Final exponent ≥ 2^EXP_W−1: result is signed Inf, overflow=1.
  - Final exponent ≤ 0: result is signed zero, underflow=1.
- Results always leave in acceptance order. No operation is dropped or duplicated under any pattern of in_valid and out_ready.

## Timing
- Reset (async, immediate): out=0, out_flags=0, out_valid=0, all stage valid bits=0. in_ready=1 once rst_n is low or out_valid is 0.
- Latency: an operation accepted at edge k appears on out_valid/out after edge k+3, provided there is no stall.
- Throughput: 1 op/cycle with out_ready held high.
- While stalled: out, out_flags and out_valid are held stable. Inputs presented during a stall are not accepted.
- Bubbles (in_valid=0) travel down the pipe as invalid stages. They do not block acceptance because stages advance whenever !stall.
- Reset asserted mid-operation: all in-flight results are discarded. The first result after rst_n deasserts belongs to the first post-reset acceptance.
- Simultaneous accept and release in the same cycle (out_ready=1, in_valid=1): both take effect.

## Test plan
- Add, default params: in_a=0x3F80, in_b=0x4000, mode=00 → out=0x4040, flags=00, out_valid exactly 3 cycles after acceptance.
- Sub and mul: 0x4040−0x4040 (mode 01) → 0x0000. 0x3FC0×0x4000 (mode 10) → 0x4040. 0xBFC0×0x4000 → 0xC040.
- Rounding: 0x3F80+0x3B80 (tie) → 0x3F80. 0x3F80+0x3BC0 (above half) → 0x3F81.
- Overflow/underflow: 0x7F00×0x4000 → 0x7F80, flags=10. 0x0080×0x0080 → 0x0000, flags=01. Denormal input 0x0001+0x3F80 → 0x3F80.
- Backpressure: issue 6 back-to-back ops with out_ready low for cycles 4–8. Required: in_ready low exactly while out_valid&&!out_ready, out held stable during the stall, and all 6 results in order with none lost.
- Reset mid-stream: assert rst_n low with 3 ops in flight. Required: outputs return to their reset values immediately, and nothing stale is emitted after release.
- Params EXP_W=5, MAN_W=10 (binary16): 0x3C00+0x4000 → 0x4200, and 0x3E00×0x4000 → 0x4200.
